// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: clock, reset and 68000 bus-cycle controller for the glue FPGA.
//
// Divides sysclk into cpuclk, holds the CPU in reset/halt for RESET_CYCLES cpuclk periods after
// sysrst, and terminates each CPU bus cycle with DTACK or BERR. Each chip-select channel either
// waits a fixed number of sysclk cycles or, when its wait field is all-ones, waits for the
// channel's ext_ack under a bus-error watchdog.
//
// Ports:
//   sysclk       in   system clock, all logic on its rising edge
//   sysrst       in   asynchronous active-high reset
//   as           in   CPU address strobe, active high
//   cs           in   [NCS] chip selects, expected one-hot or zero
//   wait_states  in   [NCS*WAIT_W] per-channel wait count, all-ones = ready-wait mode
//   ext_ack      in   [NCS] per-channel device ready, synchronous to sysclk
//   cpuclk       out  divided CPU clock
//   cpurst_n     out  CPU reset, active low
//   halt_n       out  CPU halt, same as cpurst_n
//   dtack_n      out  data acknowledge, active low, registered
//   berr_n       out  bus error, active low, registered
//   busy         out  high while a cycle is in progress
//   cycle_err    out  one-cycle pulse when a cycle enters BERR
module bus_cycle_ctrl #(
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned RESET_CYCLES = 255,
    parameter int unsigned NCS          = 4,
    parameter int unsigned WAIT_W       = 4,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic                  sysclk,
    input  logic                  sysrst,
    input  logic                  as,
    input  logic [NCS-1:0]        cs,
    input  logic [NCS*WAIT_W-1:0] wait_states,
    input  logic [NCS-1:0]        ext_ack,
    output logic                  cpuclk,
    output logic                  cpurst_n,
    output logic                  halt_n,
    output logic                  dtack_n,
    output logic                  berr_n,
    output logic                  busy,
    output logic                  cycle_err
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(BERR_TIMEOUT) + 1;
    localparam int unsigned IdxW = (NCS > 1) ? $clog2(NCS) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0]   DivHalf   = DivW'(CLK_DIV / 2);
    localparam logic [RstW-1:0]   RstLoad   = RstW'(RESET_CYCLES);
    localparam logic [ToW-1:0]    ToLast    = ToW'(BERR_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WaitReady = '1;
    localparam logic [WAIT_W-1:0] WaitOne   = WAIT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StReady,
        StAck,
        StBerr
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              cpuclk_q, cpuclk_d;
    logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic              as_q;
    logic [IdxW-1:0]   ch_q, ch_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [ToW-1:0]    tcnt_q, tcnt_d;
    logic              dtack_n_q, berr_n_q, cycle_err_q;

    logic              cpu_run;
    logic              sel_any, sel_multi;
    logic [IdxW-1:0]   sel_idx;
    logic [WAIT_W-1:0] sel_w;

    assign cpu_run = (rst_cnt_q == '0);

    // Divider and reset stretch; the stretch counts cpuclk rising edges (divider hitting half).
    always_comb begin
        div_d     = (div_q == DivLast) ? '0 : div_q + 1'b1;
        cpuclk_d  = (div_d >= DivHalf);
        rst_cnt_d = rst_cnt_q;
        if (div_d == DivHalf && rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
    end

    // Chip-select decode: index of the set bit, plus flags for none / more than one.
    always_comb begin
        sel_any   = 1'b0;
        sel_multi = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NCS; i++) begin
            if (cs[i]) begin
                if (sel_any) begin
                    sel_multi = 1'b1;
                end
                sel_any = 1'b1;
                sel_idx = IdxW'(i);
            end
        end
    end

    assign sel_w = wait_states[int'(sel_idx) * WAIT_W +: WAIT_W];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            StIdle: begin
                if (as_q && cpu_run) begin
                    if (!sel_any || sel_multi) begin
                        state_d = StBerr;
                    end else begin
                        ch_d = sel_idx;
                        if (sel_w == WaitReady) begin
                            state_d = StReady;
                            tcnt_d  = '0;
                        end else if (sel_w == '0) begin
                            state_d = StAck;
                        end else begin
                            state_d = StWait;
                            wcnt_d  = sel_w;
                        end
                    end
                end
            end
            StWait: begin
                // Leaving at count 1 gives exactly W cycles in this state.
                if (!as_q) begin
                    state_d = StIdle;
                end else if (wcnt_q == WaitOne) begin
                    state_d = StAck;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            StReady: begin
                // Ack is tested first so it beats a timeout on the same edge.
                if (!as_q) begin
                    state_d = StIdle;
                end else if (ext_ack[ch_q]) begin
                    state_d = StAck;
                end else if (tcnt_q == ToLast) begin
                    state_d = StBerr;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StAck, StBerr: begin
                if (!as_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cpuclk_q    <= 1'b0;
            rst_cnt_q   <= RstLoad;
            as_q        <= 1'b0;
            ch_q        <= '0;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            cycle_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cpuclk_q    <= cpuclk_d;
            rst_cnt_q   <= rst_cnt_d;
            as_q        <= as;
            ch_q        <= ch_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            // Strobes are registered from the next state so they change with the state itself.
            dtack_n_q   <= (state_d != StAck);
            berr_n_q    <= (state_d != StBerr);
            cycle_err_q <= (state_d == StBerr) && (state_q != StBerr);
        end
    end

    assign cpuclk    = cpuclk_q;
    assign cpurst_n  = cpu_run;
    assign halt_n    = cpu_run;
    assign dtack_n   = dtack_n_q;
    assign berr_n    = berr_n_q;
    assign busy      = (state_q != StIdle);
    assign cycle_err = cycle_err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
module tb_bus_cycle_ctrl;

    localparam int unsigned CLK_DIV      = 8;
    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned NCS          = 4;
    localparam int unsigned WAIT_W       = 4;
    localparam int unsigned BERR_TIMEOUT = 64;
    localparam int unsigned RST_EDGE     = RESET_CYCLES * CLK_DIV - CLK_DIV / 2;

    logic                  sysclk = 1'b0;
    logic                  sysrst;
    logic                  as;
    logic [NCS-1:0]        cs;
    logic [NCS*WAIT_W-1:0] wait_states;
    logic [NCS-1:0]        ext_ack;
    logic                  cpuclk, cpurst_n, halt_n, dtack_n, berr_n, busy, cycle_err;

    bus_cycle_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .RESET_CYCLES (RESET_CYCLES),
        .NCS          (NCS),
        .WAIT_W       (WAIT_W),
        .BERR_TIMEOUT (BERR_TIMEOUT)
    ) dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .as          (as),
        .cs          (cs),
        .wait_states (wait_states),
        .ext_ack     (ext_ack),
        .cpuclk      (cpuclk),
        .cpurst_n    (cpurst_n),
        .halt_n      (halt_n),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n),
        .busy        (busy),
        .cycle_err   (cycle_err)
    );

    always #5 sysclk = ~sysclk;

    // Count of rising edges seen so far; read only on falling edges.
    int unsigned cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  cs;
        logic [15:0] ws;
        logic [3:0]  ack_mask;
        int unsigned ack_at;   // ext_ack driven after edge e0+ack_at; 0 = never
        bit          exp_berr;
        int unsigned exp_lat;  // strobe falls after edge e0+exp_lat
    } vec_t;

    typedef struct {
        bit          is_berr;
        int unsigned at_edge;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int unsigned e0;
        bit          seen;
        exp_t        want;
        @(negedge sysclk);
        cs          = v.cs;
        wait_states = v.ws;
        as          = 1'b1;
        e0          = cyc + 1;
        sb.push_back('{is_berr: v.exp_berr, at_edge: e0 + v.exp_lat});
        seen = 1'b0;
        for (int n = 0; n < 120 && !seen; n++) begin
            @(negedge sysclk);
            if (cyc == e0) check($sformatf("v%0d busy before start", id), busy, 1'b0);
            if (cyc == e0 + 1) begin
                check($sformatf("v%0d busy after start", id), busy, 1'b1);
                // Selection must already be latched; scramble it.
                cs          = ~v.cs;
                wait_states = ~v.ws;
            end
            ext_ack = (v.ack_at != 0 && cyc == e0 + v.ack_at) ? v.ack_mask : 4'b0000;
            if (!dtack_n || !berr_n) begin
                seen = 1'b1;
                want = sb.pop_front();
                check($sformatf("v%0d strobe edge", id), cyc - e0, want.at_edge - e0);
                check($sformatf("v%0d dtack_n", id), dtack_n, want.is_berr);
                check($sformatf("v%0d berr_n", id), berr_n, !want.is_berr);
                check($sformatf("v%0d cycle_err", id), cycle_err, want.is_berr);
            end
        end
        ext_ack = '0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL v%0d no strobe: got none, expected strobe at e0+%0d", id, v.exp_lat);
            sb.delete();
        end
        @(negedge sysclk);
        check($sformatf("v%0d cycle_err single", id), cycle_err, 1'b0);
        check($sformatf("v%0d strobe held", id), {dtack_n, berr_n}, {v.exp_berr, !v.exp_berr});
        as = 1'b0;
        @(negedge sysclk);
        check($sformatf("v%0d strobe after as low", id), {dtack_n, berr_n},
              {v.exp_berr, !v.exp_berr});
        check($sformatf("v%0d busy after as low", id), busy, 1'b1);
        @(negedge sysclk);
        check($sformatf("v%0d strobe released", id), {dtack_n, berr_n}, 2'b11);
        check($sformatf("v%0d busy released", id), busy, 1'b0);
        cs          = '0;
        wait_states = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        bit          strobe_seen;

        vecs[0] = '{4'b0010, 16'h0030, 4'b0000, 0,  1'b0, 4};
        vecs[1] = '{4'b0001, 16'h0000, 4'b0000, 0,  1'b0, 1};
        vecs[2] = '{4'b0000, 16'h0000, 4'b0000, 0,  1'b1, 1};
        vecs[3] = '{4'b0110, 16'h0F30, 4'b0000, 0,  1'b1, 1};
        vecs[4] = '{4'b0100, 16'h0F00, 4'b0100, 10, 1'b0, 11};
        vecs[5] = '{4'b0100, 16'h0F00, 4'b0000, 0,  1'b1, 1 + BERR_TIMEOUT};
        vecs[6] = '{4'b0100, 16'h0F00, 4'b1000, 10, 1'b1, 1 + BERR_TIMEOUT};
        vecs[7] = '{4'b0100, 16'h0F00, 4'b0100, BERR_TIMEOUT, 1'b0, 1 + BERR_TIMEOUT};
        vecs[8] = '{4'b1000, 16'h1000, 4'b0000, 0,  1'b0, 2};
        vecs[9] = '{4'b0010, 16'hFF1F, 4'b0000, 0,  1'b0, 2};

        sysrst      = 1'b1;
        as          = 1'b0;
        cs          = '0;
        wait_states = '0;
        ext_ack     = '0;
        repeat (3) @(negedge sysclk);
        check("reset dtack_n", dtack_n, 1'b1);
        check("reset berr_n", berr_n, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset cycle_err", cycle_err, 1'b0);
        check("reset cpuclk", cpuclk, 1'b0);
        check("reset cpurst_n", {cpurst_n, halt_n}, 2'b00);

        // Reset release: strobe held high during the stretch must be ignored.
        as          = 1'b1;
        cs          = 4'b0001;
        sysrst      = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge sysclk);
            check($sformatf("rel cpuclk k=%0d", k), cpuclk, ((k % CLK_DIV) >= CLK_DIV / 2));
            check($sformatf("rel cpurst_n k=%0d", k), cpurst_n, (k >= RST_EDGE));
            check($sformatf("rel halt_n k=%0d", k), halt_n, (k >= RST_EDGE));
            check($sformatf("rel as ignored k=%0d", k), {dtack_n, berr_n, busy}, 3'b110);
            if (k == RST_EDGE - 2) as = 1'b0;
        end
        cs = '0;
        @(negedge sysclk);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
            @(negedge sysclk);
        end

        // Abort: strobe dropped during a 10-cycle wait.
        cs          = 4'b1000;
        wait_states = 16'hA000;
        as          = 1'b1;
        e0          = cyc + 1;
        strobe_seen = 1'b0;
        repeat (3) @(negedge sysclk);
        as = 1'b0;
        @(negedge sysclk);
        check("abort busy e0+3", busy, 1'b1);
        @(negedge sysclk);
        check("abort busy e0+4", busy, 1'b0);
        repeat (16) begin
            @(negedge sysclk);
            if (!dtack_n || !berr_n) strobe_seen = 1'b1;
        end
        check("abort no strobe", strobe_seen, 1'b0);
        check("abort idle", busy, 1'b0);
        check("abort e0 sanity", cyc - e0, 20);

        // Reset in the middle of an acknowledged cycle.
        cs          = 4'b0001;
        wait_states = 16'h0000;
        as          = 1'b1;
        repeat (3) @(negedge sysclk);
        check("mid-rst dtack before", dtack_n, 1'b0);
        sysrst = 1'b1;
        #1;
        check("mid-rst dtack_n async", dtack_n, 1'b1);
        check("mid-rst cpurst_n", {cpurst_n, halt_n}, 2'b00);
        check("mid-rst busy", busy, 1'b0);
        as = 1'b0;
        cs = '0;
        @(negedge sysclk);
        sysrst = 1'b0;
        for (int k = 1; k <= RST_EDGE; k++) begin
            @(negedge sysclk);
            if (k == RST_EDGE - 1) check("mid-rst stretch low", cpurst_n, 1'b0);
            if (k == RST_EDGE) check("mid-rst stretch high", cpurst_n, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Parametrised clock, reset and 68000 bus-cycle controller for the glue FPGA. Divides sysclk into cpuclk, stretches CPU reset after system reset, and terminates every CPU bus cycle with DTACK or BERR. Termination uses a per-chip-select wait-state count or a device ready signal, with a bus-error watchdog. Sits between the memory map's chip-select outputs and the CPU control pins, replacing fixed-latency per-device acknowledge logic.

## Interface
- CLK_DIV, 8, sysclk cycles per cpuclk period; even, >= 2
- RESET_CYCLES, 255, cpuclk periods that cpurst_n/halt_n stay low after sysrst deasserts; >= 1
- NCS, 4, number of chip-select channels
- WAIT_W, 4, width of each channel's wait-state field
- BERR_TIMEOUT, 64, sysclk cycles allowed in ready-wait mode before BERR

- sysclk  in  1  system clock; one clock, everything on its rising edge
- sysrst  in  1  asynchronous, active-high reset
- as  in  1  CPU address strobe, active high
- cs  in  NCS  chip selects from the memory map; expected one-hot or zero
- wait_states  in  NCS*WAIT_W  channel i wait count at [i*WAIT_W +: WAIT_W]; all-ones selects ready-wait mode
- ext_ack  in  NCS  per-channel device ready, synchronous to sysclk
- cpuclk  out  1  CPU clock
- cpurst_n  out  1  CPU reset, active low
- halt_n  out  1  CPU halt, equal to cpurst_n
- dtack_n  out  1  data acknowledge, active low, registered
- berr_n  out  1  bus error, active low, registered
- busy  out  1  high while a cycle is being processed (state != IDLE)
- cycle_err  out  1  one-sysclk pulse when a cycle enters BERR

## Operation
- Divider: counter 0..CLK_DIV-1, wraps. cpuclk = 0 for counts 0..CLK_DIV/2-1, 1 otherwise. Registered output.
- Reset stretch: counter loads RESET_CYCLES on sysrst. It decrements once per cpuclk rising edge (divider reaching CLK_DIV/2) and stops at 0. cpurst_n = halt_n = (counter == 0).
- as is registered once into as_q. The FSM ignores as_q while cpurst_n is low.
- FSM states: IDLE, WAIT, READY, ACK, BERR.
- IDLE with as_q=1:
  - cs zero or more than one bit set -> BERR.
  - Otherwise the selected channel's W is latched with the channel index.
  - W = all-ones -> READY with timeout counter cleared.
  - W = 0 -> ACK.
  - Otherwise -> WAIT with count = W.
- WAIT: decrement each cycle; entering count 1 -> ACK on next edge. W wait cycles exactly.
- READY: ext_ack[latched channel]=1 -> ACK. Timeout counter reaching BERR_TIMEOUT-1 without ack -> BERR. Ack wins if both occur on the same edge.
- ACK: dtack_n=0. BERR: berr_n=0, cycle_err pulses on entry.
- ACK or BERR with as_q=0 -> IDLE. The strobe is deasserted on the same edge.
- as_q falling in WAIT or READY -> IDLE immediately, with no strobe asserted (aborted cycle).
- cs and wait_states are sampled only on the IDLE exit edge. Later changes are ignored.
- Timeout counter width is clog2(BERR_TIMEOUT)+1. WAIT count width is WAIT_W.

## Timing
- Reset values: divider 0, cpuclk 0, cpurst_n 0, halt_n 0, dtack_n 1, berr_n 1, busy 0, cycle_err 0, FSM IDLE.
- cpurst_n rises on the sysclk edge of the RESET_CYCLES-th cpuclk rising edge after reset release.
- as to as_q: 1 sysclk. Let e0 be the edge where as_q first reads 1.
  - dtack_n falls after edge e0+1+W in counted mode.
  - In ready mode, dtack_n falls on the edge after the one sampling ext_ack=1.
  - Unmapped or multi-select cycles: berr_n falls after edge e0+1.
- Ready-mode timeout: berr_n falls after edge e0+1+BERR_TIMEOUT.
- Strobe release: dtack_n/berr_n return high on the first edge where as_q=0, i.e. 2 sysclk after as falls.
- sysrst mid-cycle: strobes deassert asynchronously, FSM IDLE, and reset stretch restarts.
- Back-to-back cycles: a new cycle starts only after passing through IDLE; as_q must read 0 for at least one edge.

## Test plan
- Reset release with CLK_DIV=8, RESET_CYCLES=4:
  - cpuclk period is 8 sysclk, low first 4.
  - cpurst_n/halt_n rise at the 4th cpuclk rising edge.
  - as is ignored while they are low.
- cs=0010, channel 1 W=3, as held high -> dtack_n low after e0+4. It stays low until as drops, then high 2 cycles later; busy tracks the cycle.
- cs=0001, W=0 -> dtack_n low after e0+1. Then cs=0000 or cs=0110 -> berr_n low after e0+1, with a single-cycle cycle_err pulse.
- Channel 2 W=4'hF:
  - ext_ack[2] pulses at e0+10 -> dtack_n low next edge.
  - With no ack -> berr_n low after e0+65 (BERR_TIMEOUT=64).
  - ext_ack[3] alone never acknowledges.
- as dropped at e0+2 during W=10 -> no strobe, FSM IDLE. Ack and timeout coinciding -> DTACK, no BERR.
- sysrst pulsed during ACK -> dtack_n high immediately, cpurst_n low, and the stretch restarts from RESET_CYCLES.
